// File: rtl/req_arb_pkg.sv
// Shared types and helpers for the request capture arbiter feeding the 8-to-3 encoder.
package req_arb_pkg;

  localparam int unsigned ARB_N               = 8;
  localparam int unsigned ARB_PTR_W           = $clog2(ARB_N);
  localparam int unsigned SYNC_STAGES_DEFAULT = 2;
  localparam int unsigned CNT_W_DEFAULT       = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // First set bit at or above ptr, wrapping past ARB_N-1 to 0; all-zero if none.
  function automatic logic [ARB_N-1:0] rr_select(input logic [ARB_N-1:0]     pend,
                                                 input logic [ARB_PTR_W-1:0] ptr);
    logic [ARB_N-1:0]     sel;
    logic                 found;
    logic [ARB_PTR_W-1:0] idx;
    sel   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < ARB_N; k++) begin
      idx = ARB_PTR_W'((32'(ptr) + k) % ARB_N);
      if (!found && pend[idx]) begin
        sel[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [ARB_PTR_W-1:0] onehot_to_idx(input logic [ARB_N-1:0] oh);
    logic [ARB_PTR_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < ARB_N; i++) begin
      if (oh[i]) begin
        idx = idx | ARB_PTR_W'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic [ARB_PTR_W-1:0] next_ptr(input logic [ARB_PTR_W-1:0] idx);
    return (idx == ARB_PTR_W'(ARB_N - 1)) ? '0 : idx + ARB_PTR_W'(1);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// W-wide, STAGES-deep flop synchroniser for asynchronous level inputs.
module bit_sync #(
  parameter int unsigned W      = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [STAGES-1:0][W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/req_capture_arbiter.sv
// Captures request edges into a pending register and issues a held, strictly one-hot
// round-robin grant to the 8-to-3 encoder. N must equal ARB_N (the selector width).
module req_capture_arbiter
  import req_arb_pkg::*;
#(
  parameter int unsigned N           = ARB_N,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_in,
  output logic [N-1:0]     grant_onehot,
  output logic             grant_valid,
  input  logic             grant_ack,
  output logic [N-1:0]     pending,
  output logic [CNT_W-1:0] drop_count
);

  localparam logic [0:0] S_IDLE  = IDLE;
  localparam logic [0:0] S_GRANT = GRANT;

  logic [N-1:0]         req_s;
  logic [N-1:0]         req_prev_q;
  logic [N-1:0]         rise;
  logic                 ack_fire;
  logic [N-1:0]         clr_mask;
  logic [N-1:0]         remain;
  logic [N-1:0]         pending_n;
  logic                 drop_hit;
  logic [0:0]           state_q;
  logic [0:0]           state_n;
  logic [N-1:0]         grant_n;
  logic                 valid_n;
  logic [ARB_PTR_W-1:0] rr_ptr_q;
  logic [ARB_PTR_W-1:0] ptr_n;

  bit_sync #(
    .W      (N),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (req_in),
    .q     (req_s)
  );

  // Edge capture; set beats an ack-clear of the same bit and is not a drop.
  always_comb begin
    rise      = req_s & ~req_prev_q;
    ack_fire  = (state_q == S_GRANT) && grant_ack;
    clr_mask  = ack_fire ? grant_onehot : '0;
    remain    = pending & ~grant_onehot;
    pending_n = (pending & ~clr_mask) | rise;
    drop_hit  = |(rise & pending & ~clr_mask);
  end

  always_comb begin
    state_n = state_q;
    grant_n = grant_onehot;
    valid_n = grant_valid;
    ptr_n   = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (|pending) begin
          grant_n = N'(rr_select(ARB_N'(pending), rr_ptr_q));
          valid_n = 1'b1;
          state_n = S_GRANT;
        end
      end
      S_GRANT: begin
        if (grant_ack) begin
          ptr_n = next_ptr(onehot_to_idx(ARB_N'(grant_onehot)));
          // Back-to-back handoff: next grant chosen from what stays pending, no bubble.
          if (|remain) begin
            grant_n = N'(rr_select(ARB_N'(remain), ptr_n));
          end else begin
            grant_n = '0;
            valid_n = 1'b0;
            state_n = S_IDLE;
          end
        end
      end
      default: begin
        grant_n = '0;
        valid_n = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_onehot <= '0;
      grant_valid  <= 1'b0;
      rr_ptr_q     <= '0;
    end else begin
      state_q      <= state_n;
      grant_onehot <= grant_n;
      grant_valid  <= valid_n;
      rr_ptr_q     <= ptr_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_prev_q <= '0;
      pending    <= '0;
    end else begin
      req_prev_q <= req_s;
      pending    <= pending_n;
    end
  end

  // Saturating drop counter: at most +1 per cycle regardless of how many bits dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (drop_hit && !(&drop_count)) begin
      drop_count <= drop_count + CNT_W'(1);
    end
  end

endmodule
